gpu_cmd_queue: RTL and testbench

GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

---
 rtl/gpu_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 51 +++++
 rtl/gpu_cmd_queue.sv | 144 ++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared command format and opcode encoding for the GPU command queue.
package gpu_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned COORD_W  = 16;
  localparam int unsigned WIDTH_W  = 11;
  localparam int unsigned HEIGHT_W = 10;

  typedef enum logic [1:0] {
    OP_DRAW  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_SWAP  = 2'b10,
    OP_RSVD  = 2'b11
  } gpu_op_e;

  typedef struct packed {
    gpu_op_e               op;
    logic [ADDR_W-1:0]     addr;
    logic [COORD_W-1:0]    addr_x;
    logic [COORD_W-1:0]    addr_y;
    logic [COORD_W-1:0]    img_width;
    logic [WIDTH_W-1:0]    width;
    logic [HEIGHT_W-1:0]   height;
    logic [WIDTH_W-1:0]    x;
    logic [HEIGHT_W-1:0]   y;
    logic [COORD_W-1:0]    clear_color;
  } gpu_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is presented combinationally.
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;
  T            mem_q [DEPTH];

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: empty is decided by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Queues CPU commands and issues them to the GPU one at a time, pacing on
// gpu_busy handshakes and, for buffer swaps, on the next vsync rising edge.
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  gpu_cmd_t                cmd_data,
  output gpu_cmd_t                gpu_cmd,
  output logic                    gpu_draw,
  output logic                    gpu_clear,
  output logic                    swap_buffers,
  input  logic                    gpu_busy,
  input  logic                    vsync,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle,
  output logic                    op_err
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_WAIT_VS
  } state_e;

  state_e        state_q, state_d;
  gpu_cmd_t      cmd_q, cmd_d;
  logic          draw_q, draw_d;
  logic          clear_q, clear_d;
  logic          swap_q, swap_d;
  logic          op_err_q, op_err_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [2:0]    vs_q, vs_d;

  gpu_cmd_t fifo_head;
  logic     fifo_full, fifo_empty, fifo_pop;
  logic     vs_rise;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (gpu_cmd_t)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (cmd_valid),
    .pop    (fifo_pop),
    .wdata  (cmd_data),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  // vs_q[0] metastability stage, vs_q[1] synchronised level, vs_q[2] previous level.
  assign vs_d    = {vs_q[1:0], vsync};
  assign vs_rise = vs_q[1] && !vs_q[2];

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    draw_d   = 1'b0;
    clear_d  = 1'b0;
    swap_d   = 1'b0;
    op_err_d = op_err_q;
    tmo_d    = tmo_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !gpu_busy) begin
          fifo_pop = 1'b1;
          if (fifo_head.op == OP_RSVD) begin
            op_err_d = 1'b1;
          end else begin
            cmd_d   = fifo_head;
            draw_d  = (fifo_head.op == OP_DRAW);
            clear_d = (fifo_head.op == OP_CLEAR);
            swap_d  = (fifo_head.op == OP_SWAP);
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = (cmd_q.op == OP_SWAP) ? S_WAIT_VS : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (gpu_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q >= CW'(ACK_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else if (tmo_q != CW'(ACK_TIMEOUT)) begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!gpu_busy) state_d = S_IDLE;
      end
      S_WAIT_VS: begin
        if (vs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      draw_q   <= 1'b0;
      clear_q  <= 1'b0;
      swap_q   <= 1'b0;
      op_err_q <= 1'b0;
      tmo_q    <= '0;
      vs_q     <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      draw_q   <= draw_d;
      clear_q  <= clear_d;
      swap_q   <= swap_d;
      op_err_q <= op_err_d;
      tmo_q    <= tmo_d;
      vs_q     <= vs_d;
    end
  end

  assign cmd_ready    = !fifo_full;
  assign gpu_cmd      = cmd_q;
  assign gpu_draw     = draw_q;
  assign gpu_clear    = clear_q;
  assign swap_buffers = swap_q;
  assign op_err       = op_err_q;
  assign idle         = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Self-checking bench for gpu_cmd_queue: directed scenarios plus a randomized
// run scored against an in-order list of expected issued commands.
module tb_gpu_cmd_queue;
  import gpu_pkg::*;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned ACK_TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   cmd_valid;
  logic                   cmd_ready;
  gpu_cmd_t               cmd_data;
  gpu_cmd_t               gpu_cmd;
  logic                   gpu_draw, gpu_clear, swap_buffers;
  logic                   gpu_busy;
  logic                   vsync;
  logic [$clog2(DEPTH):0] level;
  logic                   idle;
  logic                   op_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic [2:0]  s;
    gpu_cmd_t    cmd;
    int unsigned cyc;
  } ev_t;

  ev_t      ev_q[$];
  gpu_cmd_t exp_q[$];

  gpu_cmd_queue #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .gpu_cmd      (gpu_cmd),
    .gpu_draw     (gpu_draw),
    .gpu_clear    (gpu_clear),
    .swap_buffers (swap_buffers),
    .gpu_busy     (gpu_busy),
    .vsync        (vsync),
    .level        (level),
    .idle         (idle),
    .op_err       (op_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log, sampled mid-cycle: {swap_buffers, gpu_clear, gpu_draw}.
  always @(negedge clk) begin
    if ({swap_buffers, gpu_clear, gpu_draw} != 3'b000)
      ev_q.push_back('{s: {swap_buffers, gpu_clear, gpu_draw}, cmd: gpu_cmd, cyc: cyc});
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic gpu_cmd_t rand_cmd(input logic [1:0] op);
    gpu_cmd_t c;
    c.op          = gpu_op_e'(op);
    c.addr        = 32'($urandom());
    c.addr_x      = 16'($urandom());
    c.addr_y      = 16'($urandom());
    c.img_width   = 16'($urandom());
    c.width       = 11'($urandom());
    c.height      = 10'($urandom());
    c.x           = 11'($urandom());
    c.y           = 10'($urandom());
    c.clear_color = 16'($urandom());
    return c;
  endfunction

  // Reference opcode -> strobe map, bits {swap, clear, draw}.
  function automatic logic [2:0] strobe_of(input gpu_op_e op);
    case (op)
      OP_DRAW:  return 3'b001;
      OP_CLEAR: return 3'b010;
      OP_SWAP:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  task automatic push(input gpu_cmd_t c, output int unsigned acc_cyc);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
    if (ok && c.op != OP_RSVD) exp_q.push_back(c);
    if (!ok) begin
      n_checks++;
      $display("FAIL push_timeout got cmd_ready=0 for 40 cycles, required acceptance");
    end
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
    end
    if (!idle) begin
      n_checks++;
      $display("FAIL idle_timeout got idle=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    gpu_busy  = 1'b0;
    vsync     = 1'b0;
    tick();
    tick();
    n_checks++;
    if (level !== '0) $display("FAIL reset_level got %0d required 0", level); else n_pass++;
    n_checks++;
    if (idle !== 1'b1) $display("FAIL reset_idle got %b required 1", idle); else n_pass++;
    n_checks++;
    if ({swap_buffers, gpu_clear, gpu_draw} !== 3'b000)
      $display("FAIL reset_strobes got %b required 000", {swap_buffers, gpu_clear, gpu_draw});
    else n_pass++;
    n_checks++;
    if (gpu_cmd !== '0) $display("FAIL reset_gpu_cmd got %h required 0", gpu_cmd); else n_pass++;
    n_checks++;
    if (op_err !== 1'b0) $display("FAIL reset_op_err got %b required 0", op_err); else n_pass++;
    resetn = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_single_draw();
    gpu_cmd_t    c;
    int unsigned e0;
    logic        idle9, idle10;
    ev_q.delete();
    exp_q.delete();
    c = rand_cmd(2'b00);
    push(c, e0);
    idle9  = 1'bx;
    idle10 = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      tick();
      gpu_busy = (cyc >= e0 + 4) && (cyc <= e0 + 8);
      if (cyc == e0 + 9)  idle9  = idle;
      if (cyc == e0 + 10) idle10 = idle;
    end
    gpu_busy = 1'b0;
    n_checks++;
    if (ev_q.size() != 1) $display("FAIL draw_count got %0d strobes required 1", ev_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (ev_q[0].s !== 3'b001) $display("FAIL draw_kind got %b required 001", ev_q[0].s); else n_pass++;
      n_checks++;
      if (ev_q[0].cyc != e0 + 2 - 1)
        $display("FAIL draw_latency got cycle %0d required %0d", ev_q[0].cyc, e0 + 1);
      else n_pass++;
      n_checks++;
      if (ev_q[0].cmd !== c) $display("FAIL draw_cmd got %h required %h", ev_q[0].cmd, c); else n_pass++;
    end
    n_checks++;
    if (idle9 !== 1'b0) $display("FAIL draw_idle_early got %b required 0", idle9); else n_pass++;
    n_checks++;
    if (idle10 !== 1'b1) $display("FAIL draw_idle_return got %b required 1", idle10); else n_pass++;
    n_checks++;
    if (gpu_cmd !== c) $display("FAIL draw_cmd_stable got %h required %h", gpu_cmd, c); else n_pass++;
  endtask

  task automatic test_full();
    gpu_cmd_t    cmds [9];
    int unsigned acc;
    ev_q.delete();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      cmds[i] = rand_cmd(2'($urandom_range(0, 1)));
      exp_q.push_back(cmds[i]);
    end
    gpu_busy  = 1'b1;
    acc       = 0;
    cmd_valid = 1'b1;
    cmd_data  = cmds[0];
    for (int i = 0; i < 20 && acc < 8; i++) begin
      if (cmd_ready) acc++;
      tick();
      cmd_data = cmds[acc];
    end
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL full_ready got %b required 0 after %0d accepts", cmd_ready, acc); else n_pass++;
    n_checks++;
    if (level !== 4'd8) $display("FAIL full_level got %0d required 8", level); else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (level !== 4'd8 || cmd_ready !== 1'b0)
      $display("FAIL full_refuse got level=%0d ready=%b required 8/0", level, cmd_ready);
    else n_pass++;
    gpu_busy = 1'b0;
    tick();
    n_checks++;
    if (level !== 4'd7 || cmd_ready !== 1'b1)
      $display("FAIL full_first_pop got level=%0d ready=%b required 7/1", level, cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (level !== 4'd8) $display("FAIL full_ninth got level=%0d required 8", level); else n_pass++;
    wait_idle(500);
    n_checks++;
    if (ev_q.size() != exp_q.size())
      $display("FAIL full_issue_count got %0d required %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i].s !== strobe_of(exp_q[i].op) || ev_q[i].cmd !== exp_q[i])
        $display("FAIL full_issue[%0d] got %b/%h required %b/%h", i, ev_q[i].s, ev_q[i].cmd,
                 strobe_of(exp_q[i].op), exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_timeout();
    gpu_cmd_t    c1, c2;
    int unsigned e0, e1;
    ev_q.delete();
    exp_q.delete();
    gpu_busy = 1'b0;
    c1 = rand_cmd(2'b01);
    c2 = rand_cmd(2'b00);
    push(c1, e0);
    push(c2, e1);
    wait_idle(100);
    n_checks++;
    if (ev_q.size() != 2) $display("FAIL clear_count got %0d strobes required 2", ev_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (ev_q[0].s !== 3'b010 || ev_q[0].cyc != e0 + 1)
        $display("FAIL clear_pulse got %b@%0d required 010@%0d", ev_q[0].s, ev_q[0].cyc, e0 + 1);
      else n_pass++;
      n_checks++;
      if (ev_q[1].s !== 3'b001 || ev_q[1].cyc - ev_q[0].cyc != ACK_TIMEOUT + 2)
        $display("FAIL clear_timeout got %b gap %0d required 001 gap %0d", ev_q[1].s,
                 ev_q[1].cyc - ev_q[0].cyc, ACK_TIMEOUT + 2);
      else n_pass++;
    end
  endtask

  task automatic test_swap();
    gpu_cmd_t    c1, c2;
    int unsigned e0, e1, s_cyc;
    ev_q.delete();
    exp_q.delete();
    vsync = 1'b0;
    c1 = rand_cmd(2'b10);
    c2 = rand_cmd(2'b00);
    push(c1, e0);
    push(c2, e1);
    s_cyc = e0 + 1;
    for (int i = 0; i < 200 && cyc < s_cyc + 100; i++) tick();
    n_checks++;
    if (ev_q.size() != 1) $display("FAIL swap_hold got %0d strobes before vsync required 1", ev_q.size());
    else n_pass++;
    vsync = 1'b1;
    for (int i = 0; i < 20 && ev_q.size() < 2; i++) tick();
    vsync = 1'b0;
    n_checks++;
    if (ev_q.size() != 2) $display("FAIL swap_count got %0d strobes required 2", ev_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (ev_q[0].s !== 3'b100 || ev_q[0].cyc != s_cyc)
        $display("FAIL swap_pulse got %b@%0d required 100@%0d", ev_q[0].s, ev_q[0].cyc, s_cyc);
      else n_pass++;
      n_checks++;
      if (ev_q[1].s !== 3'b001 || ev_q[1].cyc != s_cyc + 104)
        $display("FAIL swap_draw_after_vs got %b@%0d required 001@%0d", ev_q[1].s, ev_q[1].cyc, s_cyc + 104);
      else n_pass++;
    end
    wait_idle(60);
  endtask

  task automatic test_reserved();
    gpu_cmd_t    r, c2;
    int unsigned e0, e1;
    ev_q.delete();
    exp_q.delete();
    r  = rand_cmd(2'b11);
    c2 = rand_cmd(2'b00);
    push(r, e0);
    n_checks++;
    if (op_err !== 1'b0) $display("FAIL rsvd_err_early got %b required 0", op_err); else n_pass++;
    push(c2, e1);
    n_checks++;
    if (op_err !== 1'b1) $display("FAIL rsvd_err_set got %b required 1", op_err); else n_pass++;
    wait_idle(60);
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].s !== 3'b001 || ev_q[0].cyc != e0 + 2 || ev_q[0].cmd !== c2)
      $display("FAIL rsvd_then_draw got %0d strobes (first %b@%0d) required one 001@%0d",
               ev_q.size(), (ev_q.size() > 0) ? ev_q[0].s : 3'b000,
               (ev_q.size() > 0) ? ev_q[0].cyc : 0, e0 + 2);
    else n_pass++;
    n_checks++;
    if (op_err !== 1'b1) $display("FAIL rsvd_err_sticky got %b required 1", op_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int unsigned e0;
    ev_q.delete();
    exp_q.delete();
    push(rand_cmd(2'b00), e0);
    tick();
    n_checks++;
    if (gpu_draw !== 1'b1) $display("FAIL rstmid_pre_strobe got %b required 1", gpu_draw); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (gpu_draw !== 1'b0 || op_err !== 1'b0)
      $display("FAIL rstmid_strobe_drop got draw=%b op_err=%b required 0/0", gpu_draw, op_err);
    else n_pass++;
    tick();
    resetn = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready got %b required 1", cmd_ready); else n_pass++;

    push(rand_cmd(2'b00), e0);
    tick();
    tick();
    gpu_busy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) push(rand_cmd(2'($urandom_range(0, 1))), e0);
    n_checks++;
    if (level !== 4'd3 || idle !== 1'b0)
      $display("FAIL rstmid_queued got level=%0d idle=%b required 3/0", level, idle);
    else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (level !== '0 || idle !== 1'b1 || {swap_buffers, gpu_clear, gpu_draw} !== 3'b000 || gpu_cmd !== '0)
      $display("FAIL rstmid_state got level=%0d idle=%b strobes=%b cmd=%h required 0/1/000/0",
               level, idle, {swap_buffers, gpu_clear, gpu_draw}, gpu_cmd);
    else n_pass++;
    tick();
    tick();
    resetn   = 1'b1;
    gpu_busy = 1'b0;
    ev_q.delete();
    repeat (30) tick();
    n_checks++;
    if (ev_q.size() != 0 || idle !== 1'b1 || level !== '0)
      $display("FAIL rstmid_after got %0d strobes idle=%b level=%0d required 0/1/0", ev_q.size(), idle, level);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned sent, n;
    bit          exp_rsvd, acc_now;
    logic [1:0]  op;
    ev_q.delete();
    exp_q.delete();
    exp_rsvd = 1'b0;
    sent     = 0;
    n        = 0;
    while ((sent < 60 || !idle || cmd_valid) && n < 5000) begin
      gpu_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) vsync = ~vsync;
      if (!cmd_valid && sent < 60 && $urandom_range(0, 2) == 0) begin
        op        = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        cmd_valid = 1'b1;
        cmd_data  = rand_cmd(op);
      end
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        if (cmd_data.op == OP_RSVD) exp_rsvd = 1'b1;
        else exp_q.push_back(cmd_data);
        sent++;
      end
      tick();
      if (acc_now) cmd_valid = 1'b0;
      n++;
    end
    gpu_busy = 1'b0;
    n_checks++;
    if (n >= 5000) $display("FAIL rand_drain got %0d sent, idle=%b after 5000 cycles required drained", sent, idle);
    else n_pass++;
    n_checks++;
    if (ev_q.size() != exp_q.size())
      $display("FAIL rand_issue_count got %0d required %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i].s !== strobe_of(exp_q[i].op) || ev_q[i].cmd !== exp_q[i])
        $display("FAIL rand_issue[%0d] got %b/%h required %b/%h", i, ev_q[i].s, ev_q[i].cmd,
                 strobe_of(exp_q[i].op), exp_q[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (ev_q[i].cyc - ev_q[i-1].cyc < 2)
          $display("FAIL rand_pulse_gap[%0d] got %0d cycles required >=2", i, ev_q[i].cyc - ev_q[i-1].cyc);
        else n_pass++;
      end
    end
    n_checks++;
    if (op_err !== exp_rsvd) $display("FAIL rand_op_err got %b required %b", op_err, exp_rsvd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_draw();
    test_full();
    test_clear_timeout();
    test_swap();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
